// File: rtl/perf_counter_bank.sv
// perf_counter_bank: configurable bank of core performance counters with halt freeze and shadow snapshot.
// Latency: counters and stat outputs update one edge after the sampled event; rd_data is combinational from the shadow bank.
// Backpressure: none; every cycle is accepted. Build option PERF_SAT_EN selects saturating counters (default: wrap to 0).
module perf_counter_bank #(
  parameter int CNT_W   = 32,
  parameter int NUM_EXT = 2,
  parameter int SEL_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               inst_valid,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic               halt,
  input  logic [NUM_EXT-1:0] ext_ev,
  input  logic               clear,
  input  logic               snap,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [CNT_W-1:0]   statTC,
  output logic [CNT_W-1:0]   statR,
  output logic [CNT_W-1:0]   statI,
  output logic [CNT_W-1:0]   statJ,
  output logic               halted,
  output logic               ovf
);

  // Fixed counter slots; external channels follow the built-in ones.
  localparam int IDX_TC     = 0;
  localparam int IDX_RET    = 1;
  localparam int IDX_R      = 2;
  localparam int IDX_I      = 3;
  localparam int IDX_J      = 4;
  localparam int IDX_BR     = 5;
  localparam int IDX_STALL  = 6;
  localparam int IDX_SYS    = 7;
  localparam int IDX_EXT0   = 8;
  localparam int NUM_CNT    = IDX_EXT0 + NUM_EXT;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t           state_q;
  logic             halted_q;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [CNT_W-1:0] cnt_d [NUM_CNT];
  logic [CNT_W-1:0] shd_q [NUM_CNT];
  logic [NUM_CNT-1:0] inc;

  logic retire;
  logic is_r;
  logic is_j;
  logic is_sys;

  // Decode the retire slot and pipeline strobes into one increment request per counter.
  always_comb begin
    inc    = '0;
    retire = inst_valid && !stall;
    is_r   = (op == 6'h00);
    is_j   = (op == 6'h02) || (op == 6'h03);
    is_sys = is_r && (funct == 6'h0C);

    inc[IDX_TC]    = 1'b1;
    inc[IDX_RET]   = retire;
    inc[IDX_R]     = retire && is_r;
    inc[IDX_I]     = retire && !is_r && !is_j;
    inc[IDX_J]     = retire && is_j;
    inc[IDX_BR]    = branch_taken;
    inc[IDX_STALL] = stall;
    inc[IDX_SYS]   = retire && is_sys;
    for (int k = 0; k < NUM_EXT; k++) begin
      inc[IDX_EXT0 + k] = ext_ev[k];
    end
  end

  // Next counter values: clear beats counting, HALTED freezes, all-ones either wraps or holds.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if ((state_q == ST_RUN) && inc[i]) begin
        if (&cnt_q[i]) begin
          // Overflow is flagged the same way whether the counter wraps or saturates.
          ovf_d = 1'b1;
`ifdef PERF_SAT_EN
          cnt_d[i] = cnt_q[i];
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    if (clear) begin
      ovf_d = 1'b0;
    end
  end

  // Live counter bank and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  // Shadow bank captures the pre-update live values, so a snap alongside clear keeps the old counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shd_q[i] <= '0;
      end
    end else if (snap) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shd_q[i] <= cnt_q[i];
      end
    end
  end

  // RUN/HALTED control with a registered halted flag; halt is ignored once halted, only clear resumes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!clear && halt) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (clear) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Shadow readout; indices past the last implemented counter read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (32'(rd_sel) == 32'(i)) begin
        rd_data = shd_q[i];
      end
    end
  end

  assign statTC = cnt_q[IDX_TC];
  assign statR  = cnt_q[IDX_R];
  assign statI  = cnt_q[IDX_I];
  assign statJ  = cnt_q[IDX_J];
  assign halted = halted_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a 32-bit and an 8-bit instance share one stimulus stream.
// The reference keeps true (unbounded) event counts and derives wrap/saturate views per width.
module tb_perf_counter_bank;

  localparam int NE = 2;
  localparam int NC = 8 + NE;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op, funct;
  logic          inst_valid, stall, branch_taken, halt, clear, snap;
  logic [NE-1:0] ext_ev;
  logic [3:0]    rd_sel;

  logic [31:0] rd32, tc32, r32, i32, j32;
  logic        halted32, ovf32;
  logic [7:0]  rd8, tc8, r8, i8, j8;
  logic        halted8, ovf8;

  int compares = 0;
  int fails    = 0;

  longint m_cnt [NC];
  longint m_shd [NC];
  bit     m_halt;

  always #5 clk = ~clk;

  perf_counter_bank #(.CNT_W(32), .NUM_EXT(NE), .SEL_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .inst_valid(inst_valid),
    .stall(stall), .branch_taken(branch_taken), .halt(halt), .ext_ev(ext_ev),
    .clear(clear), .snap(snap), .rd_sel(rd_sel), .rd_data(rd32),
    .statTC(tc32), .statR(r32), .statI(i32), .statJ(j32),
    .halted(halted32), .ovf(ovf32)
  );

  perf_counter_bank #(.CNT_W(8), .NUM_EXT(NE), .SEL_W(4)) dut8 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .inst_valid(inst_valid),
    .stall(stall), .branch_taken(branch_taken), .halt(halt), .ext_ev(ext_ev),
    .clear(clear), .snap(snap), .rd_sel(rd_sel), .rd_data(rd8),
    .statTC(tc8), .statR(r8), .statI(i8), .statJ(j8),
    .halted(halted8), .ovf(ovf8)
  );

  // Value a w-bit counter shows after v true increments.
  function automatic logic [63:0] expv(int w, longint v);
    longint lim = longint'(1) << w;
    if (v < lim) return v;
`ifdef PERF_SAT_EN
    return lim - 1;
`else
    return v % lim;
`endif
  endfunction

  // Overflow happened iff some counter received at least 2^w increments since the last clear.
  function automatic logic exp_ovf(int w);
    longint lim = longint'(1) << w;
    for (int i = 0; i < NC; i++) if (m_cnt[i] >= lim) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_rd(int w);
    if (int'(rd_sel) < NC) return expv(w, m_shd[rd_sel]);
    return 64'd0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0;
      m_shd[i] = 0;
    end
    m_halt = 1'b0;
  endtask

  // Reference behaviour for one rising edge, from the event rules.
  task automatic model_edge();
    bit ret;
    if (reset) return;
    if (snap) m_shd = m_cnt;
    if (clear) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      ret = inst_valid && !stall;
      m_cnt[0]++;
      if (ret) begin
        m_cnt[1]++;
        if (op == 6'h00) m_cnt[2]++;
        else if (op == 6'h02 || op == 6'h03) m_cnt[4]++;
        else m_cnt[3]++;
        if (op == 6'h00 && funct == 6'h0C) m_cnt[7]++;
      end
      if (branch_taken) m_cnt[5]++;
      if (stall) m_cnt[6]++;
      for (int k = 0; k < NE; k++) if (ext_ev[k]) m_cnt[8+k]++;
      if (halt) m_halt = 1'b1;
    end
  endtask

  task automatic check_all(string tag);
    rd_sel = 4'($urandom_range(0, 15));
    #1;
    chk({tag, " tc32"}, tc32, expv(32, m_cnt[0]));
    chk({tag, " r32"},  r32,  expv(32, m_cnt[2]));
    chk({tag, " i32"},  i32,  expv(32, m_cnt[3]));
    chk({tag, " j32"},  j32,  expv(32, m_cnt[4]));
    chk({tag, " rd32"}, rd32, exp_rd(32));
    chk({tag, " halted32"}, halted32, m_halt);
    chk({tag, " ovf32"}, ovf32, exp_ovf(32));
    chk({tag, " tc8"},  tc8,  expv(8, m_cnt[0]));
    chk({tag, " r8"},   r8,   expv(8, m_cnt[2]));
    chk({tag, " i8"},   i8,   expv(8, m_cnt[3]));
    chk({tag, " j8"},   j8,   expv(8, m_cnt[4]));
    chk({tag, " rd8"},  rd8,  exp_rd(8));
    chk({tag, " halted8"}, halted8, m_halt);
    chk({tag, " ovf8"}, ovf8, exp_ovf(8));
  endtask

  task automatic idle();
    op = 6'h00; funct = 6'h00; inst_valid = 0; stall = 0; branch_taken = 0;
    halt = 0; clear = 0; snap = 0; ext_ev = '0;
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic read_shadow(string tag, int sel, logic [63:0] exp32);
    rd_sel = 4'(sel);
    #1;
    chk({tag, " rd32"}, rd32, exp32);
    chk({tag, " rd8"}, rd8, expv(8, exp32));
  endtask

  // Reset between clock edges; outputs must drop without waiting for an edge.
  task automatic do_reset(string tag);
    #2;
    reset = 1'b1;
    model_clear_all();
    check_all(tag);
    chk({tag, " tc32 now"}, tc32, 0);
    chk({tag, " rd32 now"}, rd32, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] seq [10];
    seq = '{6'h00, 6'h23, 6'h02, 6'h00, 6'h08, 6'h03, 6'h2B, 6'h00, 6'h04, 6'h02};
    idle();
    rd_sel = 0;
    reset  = 1'b1;
    model_clear_all();
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Opcode mix: 3 R, 4 I, 3 J over 10 retires.
    for (int n = 0; n < 10; n++) begin
      inst_valid = 1; op = seq[n];
      cycle("mix");
    end
    chk("mix tc", tc32, 10);
    chk("mix R", r32, 3);
    chk("mix I", i32, 4);
    chk("mix J", j32, 3);
    idle(); snap = 1;
    cycle("mix snap");
    read_shadow("mix retired", 1, 10);

    // Stalled slot: cycles count, retires do not.
    idle();
    for (int n = 0; n < 5; n++) begin
      inst_valid = 1; stall = 1; op = 6'h23;
      cycle("stall");
    end
    idle(); snap = 1;
    cycle("stall snap");
    read_shadow("stall count", 6, 5);
    chk("stall R unchanged", r32, 3);

    // Halting syscall at cycle 7 after a clear, then frozen.
    idle(); clear = 1;
    cycle("clr1");
    idle();
    for (int n = 0; n < 6; n++) cycle("pre-halt");
    inst_valid = 1; op = 6'h00; funct = 6'h0C; halt = 1;
    cycle("syscall");
    chk("halt tc", tc32, 7);
    chk("halt flag", halted32, 1);
    for (int n = 0; n < 20; n++) begin
      idle(); inst_valid = 1; halt = 1'($urandom_range(0, 1)); ext_ev = 2'b11;
      cycle("frozen");
    end
    chk("frozen tc", tc32, 7);
    idle(); snap = 1;
    cycle("halted snap");
    read_shadow("syscall count", 7, 1);
    idle(); clear = 1;
    cycle("unhalt");
    chk("unhalt tc", tc32, 0);
    chk("unhalt flag", halted32, 0);

    // Long run: 8-bit instance overflows.
    idle();
    for (int n = 0; n < 260; n++) cycle("long");
    chk("long tc32", tc32, 260);
`ifdef PERF_SAT_EN
    chk("long tc8", tc8, 255);
`else
    chk("long tc8", tc8, 4);
`endif
    chk("long ovf8", ovf8, 1);
    chk("long ovf32", ovf32, 0);

    // snap with clear captures the pre-clear count.
    idle(); clear = 1;
    cycle("clr2");
    idle();
    for (int n = 0; n < 50; n++) cycle("fifty");
    chk("fifty tc", tc32, 50);
    snap = 1; clear = 1;
    cycle("snapclr");
    read_shadow("snapclr tc", 0, 50);
    chk("snapclr live", tc32, 0);
    chk("snapclr ovf8", ovf8, 0);
    read_shadow("sel15", 15, 0);

    // External channels.
    idle(); clear = 1;
    cycle("clr3");
    idle();
    for (int n = 0; n < 5; n++) begin
      ext_ev = (n < 3) ? 2'b11 : 2'b10;
      cycle("ext");
    end
    idle(); snap = 1;
    cycle("ext snap");
    read_shadow("ext0", 8, 3);
    read_shadow("ext1", 9, 5);
    idle(); inst_valid = 1; op = 6'h08;
    for (int n = 0; n < 4; n++) cycle("pre-rst");
    do_reset("midreset");
    chk("midreset ovf8", ovf8, 0);
    chk("midreset halted", halted32, 0);

    // Random traffic against the reference.
    for (int n = 0; n < 700; n++) begin
      case ($urandom_range(0, 3))
        0: op = 6'h00;
        1: op = 6'h02;
        2: op = 6'h03;
        default: op = 6'($urandom);
      endcase
      funct        = ($urandom_range(0, 3) == 0) ? 6'h0C : 6'($urandom);
      inst_valid   = 1'($urandom_range(0, 3) != 0);
      stall        = 1'($urandom_range(0, 4) == 0);
      branch_taken = 1'($urandom_range(0, 2) == 0);
      halt         = 1'($urandom_range(0, 40) == 0);
      clear        = 1'($urandom_range(0, 90) == 0);
      snap         = 1'($urandom_range(0, 6) == 0);
      ext_ev       = 2'($urandom);
      cycle("rand");
      if ($urandom_range(0, 250) == 0) do_reset("rand reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised performance-statistics unit for the CPU cores. It replaces the fixed J/R/I/total-cycle counter with a configurable bank of event counters, and adds:
- stall accounting;
- branch and syscall counts;
- external event channels;
- halt freeze;
- an atomic snapshot for readout.

It sits beside the core, fed from the decoded instruction and pipeline control. Its live outputs drive the existing stat buses, and its snapshot port serves the display/debug path.

## Interface
Parameters:
- CNT_W, 32, width of every counter.
- NUM_EXT, 2, number of external event inputs (1..8).
- SEL_W, 4, width of the readout select.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- op  in  6  opcode of the instruction in the retire slot.
- funct  in  6  funct field of that instruction.
- inst_valid  in  1  retire slot holds a real instruction.
- stall  in  1  retire slot is stalled this cycle.
- branch_taken  in  1  a taken branch or jump redirect occurs this cycle.
- halt  in  1  halt request from the syscall decoder.
- ext_ev  in  NUM_EXT  external event strobes; one count per cycle high.
- clear  in  1  synchronous counter clear.
- snap  in  1  copy all live counters into the shadow bank.
- rd_sel  in  SEL_W  shadow counter index.
- rd_data  out  CNT_W  shadow counter selected by rd_sel.
- statTC  out  CNT_W  live total-cycle counter.
- statR  out  CNT_W  live R-type retire counter.
- statI  out  CNT_W  live I-type retire counter.
- statJ  out  CNT_W  live J-type retire counter.
- halted  out  1  unit is in HALTED state.
- ovf  out  1  sticky; some counter incremented from all-ones.

## Operation
Counter indices:
- 0: total cycles
- 1: retired instructions
- 2: R-type
- 3: I-type
- 4: J-type
- 5: taken branches
- 6: stall cycles
- 7: syscalls
- 8..8+NUM_EXT-1: ext_ev[k]

Instruction classification:
- R: op==6'h00.
- J: op==6'h02 or 6'h03.
- I: every other opcode.
- Syscall: op==6'h00 and funct==6'h0C.

Retire definition: retire = inst_valid && !stall.

State machine:
- RUN (reset state): each cycle:
  - TC +1;
  - stall cycles +1 if stall;
  - retire counters +1 per class on retire;
  - branch +1 if branch_taken;
  - ext counter k +1 if ext_ev[k].
- RUN -> HALTED: when halt=1 at an edge. That edge's counts still apply, including the TC increment and the retire of the halting syscall.
- HALTED: all counters frozen, including TC. halt is ignored. Exit only via clear (to RUN) or reset.

Clear, snapshot and readout:
- clear: zeros all live counters, returns to RUN, and clears ovf. It takes priority over counting on the same edge. The shadow bank is untouched.
- snap: the shadow bank loads the live values as they were before the edge's update. snap and clear on the same edge therefore capture the pre-clear values. snap is honoured in HALTED.
- rd_data: combinational from the shadow bank. Returns 0 for rd_sel >= 8+NUM_EXT.

Arithmetic:
- Each counter is an independent CNT_W-bit unsigned value.
- Overflow behaviour is set by Configuration.

## Timing
- Reset values: all live and shadow counters 0, state RUN, halted=0, ovf=0, rd_data=0.
- Counter and stat outputs are registered and reflect events sampled at edge N after edge N.
- rd_data follows rd_sel in the same cycle, with zero-cycle latency from the shadow bank.
- halted asserts after the edge that samples halt=1.
- Reset asserted mid-operation: immediate clear of all state, regardless of the clock.
- ovf sets on the edge where any counter would increment from all-ones, in both configurations.

## Configuration
- PERF_SAT_EN defined: counters saturate at all-ones and hold.
- PERF_SAT_EN undefined: counters wrap to 0.
- ovf behaves identically in both cases.

## Test plan
- Reset, then 10 cycles with inst_valid=1 on op sequence 00,23,02,00,08,03,2B,00,04,02 → statTC=10, statR=3, statI=4, statJ=3, counter1=10.
- 5 cycles with stall=1 and inst_valid=1 → TC +5, stall counter 5, retire/class counts unchanged.
- Syscall (op=00, funct=0C) with halt=1 at cycle 7 → syscall count 1, statTC=7, halted=1; statTC remains 7 after 20 more cycles; clear → all 0, halted=0.
- CNT_W=8, 260 cycles running → statTC=4 and ovf=1 without PERF_SAT_EN; with it, statTC=255 and ovf=1.
- snap and clear on the same edge with statTC=50 → rd_sel=0 reads 50, statTC=0 next cycle; rd_sel=15 with NUM_EXT=2 → 0.
- ext_ev=2'b11 for 3 cycles, then 2'b10 for 2 cycles, then snap → counter8=3, counter9=5; reset asserted mid-stream → all outputs 0 immediately.
